// File: rtl/gmii_rx_pkg.sv
// Shared constants and state type for the GMII receive path.
// The CRC constants are kept here so a future tx FCS generator can reuse them.
package gmii_rx_pkg;

    localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
    localparam logic [7:0]  GMII_SFD      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
    localparam int          FCS_BYTES     = 4;

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        DROP
    } rx_state_t;

    // Bit-reverses a polynomial into the LSB-first form used on the wire.
    function automatic logic [31:0] reflect32(input logic [31:0] value);
        logic [31:0] result;
        for (int i = 0; i < 32; i++) begin
            result[i] = value[31 - i];
        end
        return result;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// One-byte step of the reflected Ethernet CRC32; purely combinational.
// No final inversion is applied, so the caller owns init and residue handling.
module crc32_d8
    import gmii_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

    function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [7:0] byte_in);
        logic [31:0] c;
        c = crc ^ {24'h0, byte_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    assign crc_out = crc_step(crc_in, data);

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD and FCS, emits 8-bit AXI-Stream with status.
// Define GMII_RX_FRAMER_STATS_EN to add saturating good/bad frame counters.
module gmii_rx_framer
    import gmii_rx_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
`ifdef GMII_RX_FRAMER_STATS_EN
    output logic [31:0] stat_good_count,
    output logic [31:0] stat_bad_count,
`endif
    output logic        stat_start_packet,
    output logic        stat_bad_fcs,
    output logic        stat_bad_frame
);

    localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);
    localparam logic [15:0] DL_LEN  = 16'(FCS_BYTES);

    rx_state_t        state;
    rx_state_t        state_next;
    logic [7:0]       rxd_q;
    logic             dv_q;
    logic             er_q;
    logic [3:0][7:0]  delay_line;
    logic [15:0]      len;
    logic [15:0]      len_inc;
    logic [31:0]      crc;
    logic [31:0]      crc_next;
    logic             err_sticky;

    logic             payload_beat;
    logic             frame_end;
    logic             beat_valid;
    logic             fcs_bad;
    logic             frame_bad;
    logic             enter_payload;

    logic [7:0]       tdata_d;
    logic             tvalid_d;
    logic             tlast_d;
    logic             tuser_d;
    logic             start_d;
    logic             bad_fcs_d;
    logic             bad_frame_d;

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (rxd_q),
        .crc_out (crc_next)
    );

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (dv_q) begin
                    if (rxd_q == GMII_PREAMBLE) state_next = PREAMBLE;
                    else if (rxd_q == GMII_SFD) state_next = PAYLOAD;
                    else                        state_next = DROP;
                end
            end
            PREAMBLE: begin
                if (!dv_q)                       state_next = IDLE;
                else if (er_q)                   state_next = DROP;
                else if (rxd_q == GMII_SFD)      state_next = PAYLOAD;
                else if (rxd_q != GMII_PREAMBLE) state_next = DROP;
            end
            PAYLOAD: if (!dv_q) state_next = IDLE;
            DROP:    if (!dv_q) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame end is seen one cycle early on the raw rx_dv, so the tlast beat
    // leaves together with the last payload byte and the check covers the final FCS byte.
    assign payload_beat  = (state == PAYLOAD) && dv_q;
    assign frame_end     = payload_beat && !gmii_rx_dv;
    assign beat_valid    = payload_beat && (len >= DL_LEN);
    assign len_inc       = (len == 16'hFFFF) ? len : len + 16'd1;
    assign fcs_bad       = (crc_next != CRC32_RESIDUE);
    assign frame_bad     = err_sticky || er_q || fcs_bad || (len_inc < MIN_LEN) || (len_inc > MAX_LEN);
    assign enter_payload = (state != PAYLOAD) && (state_next == PAYLOAD);

    always_comb begin
        tvalid_d    = beat_valid;
        tdata_d     = beat_valid ? delay_line[3] : 8'h00;
        tlast_d     = beat_valid && frame_end;
        tuser_d     = beat_valid && frame_end && frame_bad;
        start_d     = enter_payload;
        bad_fcs_d   = beat_valid && frame_end && fcs_bad;
        bad_frame_d = tuser_d || (frame_end && !beat_valid) || ((state == DROP) && !dv_q);
    end

    // NOTE: the 4-byte delay line is plain flops, so it is cleared on reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_q      <= 8'h00;
            dv_q       <= 1'b0;
            er_q       <= 1'b0;
            delay_line <= '0;
            len        <= 16'h0000;
            crc        <= CRC32_INIT;
            err_sticky <= 1'b0;
        end else begin
            rxd_q <= gmii_rxd;
            dv_q  <= gmii_rx_dv;
            er_q  <= gmii_rx_er;
            if (enter_payload) begin
                len        <= 16'h0000;
                crc        <= CRC32_INIT;
                err_sticky <= 1'b0;
            end else if (payload_beat) begin
                len        <= len_inc;
                crc        <= crc_next;
                err_sticky <= err_sticky || er_q;
                delay_line <= {delay_line[2:0], rxd_q};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tdata      <= 8'h00;
            m_axis_tvalid     <= 1'b0;
            m_axis_tlast      <= 1'b0;
            m_axis_tuser      <= 1'b0;
            stat_start_packet <= 1'b0;
            stat_bad_fcs      <= 1'b0;
            stat_bad_frame    <= 1'b0;
        end else begin
            m_axis_tdata      <= tdata_d;
            m_axis_tvalid     <= tvalid_d;
            m_axis_tlast      <= tlast_d;
            m_axis_tuser      <= tuser_d;
            stat_start_packet <= start_d;
            stat_bad_fcs      <= bad_fcs_d;
            stat_bad_frame    <= bad_frame_d;
        end
    end

`ifdef GMII_RX_FRAMER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_good_count <= 32'h0;
            stat_bad_count  <= 32'h0;
        end else begin
            if (m_axis_tlast && !m_axis_tuser && (stat_good_count != 32'hFFFF_FFFF))
                stat_good_count <= stat_good_count + 32'd1;
            if (stat_bad_frame && (stat_bad_count != 32'hFFFF_FFFF))
                stat_bad_count <= stat_bad_count + 32'd1;
        end
    end
`endif

endmodule
